control_fsm: RTL and testbench

Instruction-sequencing controller for the 16-bit lab processor: holds the program counter and instruction register, fetches from the instruction ROM and drives the datapath control bus. It is the initiator of the control interface that the datapath responds to. Its port set mirrors the processor top's debug outputs (IR, PC, state), so it drops in as the processor's control unit.

---
 rtl/cunit_pkg.sv | 37 +++
 rtl/pc_ir_reg.sv | 40 ++++
 rtl/control_fsm.sv | 129 ++++++++++++
 tb/tb_control_fsm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cunit_pkg.sv
// Shared definitions for the lab processor control unit: opcodes, state codes,
// ALU select values and field widths.
package cunit_pkg;

    localparam int PC_W  = 5;
    localparam int IR_W  = 16;
    localparam int DA_W  = 8;
    localparam int RA_W  = 4;
    localparam int ALU_W = 3;
    localparam int OP_W  = 4;
    localparam int ST_W  = 4;

    localparam logic [OP_W-1:0] OP_NOOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_STORE = 4'h1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD   = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
    localparam logic [OP_W-1:0] OP_HALT  = 4'h5;

    localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;

    typedef enum logic [ST_W-1:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOP    = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

endpackage

// File: rtl/pc_ir_reg.sv
// Program counter and instruction register. Both load only during Fetch;
// the PC wraps naturally from 31 to 0 through its 5-bit width.
module pc_ir_reg
    import cunit_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ld_ir_i,
    input  logic            inc_pc_i,
    input  logic [IR_W-1:0] im_data_i,
    output logic [PC_W-1:0] pc_o,
    output logic [IR_W-1:0] ir_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [IR_W-1:0] ir_q, ir_d;

    // Next values: hold unless Fetch asks for a load/increment.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if (inc_pc_i) pc_d = pc_q + 1'b1;
        if (ld_ir_i)  ir_d = im_data_i;
    end

    // PC/IR storage, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign pc_o = pc_q;
    assign ir_o = ir_q;

endmodule

// File: rtl/control_fsm.sv
// Instruction-sequencing control unit: fetch/decode/execute FSM driving the
// datapath control bus. Outputs are Moore (state + IR).
//
// state  | meaning
// -------+----------------------------------------------
// Init   | after reset, one idle cycle before first fetch
// Fetch  | IR <- ROM data, PC <- PC+1
// Decode | select execute state from opcode
// Nop    | no operation (also opcodes 6..15)
// LoadA  | present data address, wait for memory read
// LoadB  | write memory data into RF
// Store  | write RF[Ra] to data memory
// Add    | RF[W] <- RF[A] + RF[B]
// Sub    | RF[W] <- RF[A] - RF[B]
// Halt   | parked until reset
module control_fsm
    import cunit_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic [IR_W-1:0]  IM_data,
    output logic [PC_W-1:0]  IM_addr,
    output logic [IR_W-1:0]  IR_Out,
    output logic [PC_W-1:0]  PC_Out,
    output logic [ST_W-1:0]  StateO,
    output logic [DA_W-1:0]  D_addr,
    output logic             D_wr,
    output logic             RF_s,
    output logic [RA_W-1:0]  RF_W_addr,
    output logic             RF_W_wr,
    output logic [RA_W-1:0]  RF_Ra_addr,
    output logic [RA_W-1:0]  RF_Rb_addr,
    output logic             RF_Ra_rd,
    output logic             RF_Rb_rd,
    output logic [ALU_W-1:0] Alu_s0
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc;
    logic [IR_W-1:0] ir;
    logic            fetch_en;

    assign fetch_en = (state_q == S_FETCH);

    pc_ir_reg u_pc_ir (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .ld_ir_i   (fetch_en),
        .inc_pc_i  (fetch_en),
        .im_data_i (IM_data),
        .pc_o      (pc),
        .ir_o      (ir)
    );

    // State register with asynchronous reset to Init.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    // Next-state logic; unreachable codes recover to Init.
    always_comb begin
        state_d = S_INIT;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ir[15:12])
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOADA;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOP;
                endcase
            end
            S_LOADA:  state_d = S_LOADB;
            S_NOP, S_LOADB, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Control bus decoder; everything is 0 unless the state drives it.
    always_comb begin
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_wr    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        RF_Ra_rd   = 1'b0;
        RF_Rb_rd   = 1'b0;
        Alu_s0     = ALU_PASS;
        case (state_q)
            S_LOADA: D_addr = ir[11:4];
            S_LOADB: begin
                D_addr    = ir[11:4];
                RF_s      = 1'b1;
                RF_W_addr = ir[3:0];
                RF_W_wr   = 1'b1;
            end
            S_STORE: begin
                D_addr     = ir[11:4];
                D_wr       = 1'b1;
                RF_Ra_addr = ir[3:0];
                RF_Ra_rd   = 1'b1;
                Alu_s0     = ALU_PASS;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = ir[11:8];
                RF_Rb_addr = ir[7:4];
                RF_Ra_rd   = 1'b1;
                RF_Rb_rd   = 1'b1;
                RF_W_addr  = ir[3:0];
                RF_W_wr    = 1'b1;
                Alu_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign StateO  = state_q;
    assign PC_Out  = pc;
    assign IM_addr = pc;
    assign IR_Out  = ir;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm with a synchronous instruction ROM model.
module tb_control_fsm;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IM_data = 16'h0000;
    logic [4:0]  IM_addr;
    logic [15:0] IR_Out;
    logic [4:0]  PC_Out;
    logic [3:0]  StateO;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_wr;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic        RF_Ra_rd;
    logic        RF_Rb_rd;
    logic [2:0]  Alu_s0;

    logic [15:0] rom [0:31];
    int n_cmp = 0;
    int n_err = 0;

    control_fsm dut (
        .Clk(Clk), .Reset(Reset), .IM_data(IM_data), .IM_addr(IM_addr),
        .IR_Out(IR_Out), .PC_Out(PC_Out), .StateO(StateO), .D_addr(D_addr),
        .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .RF_Ra_rd(RF_Ra_rd),
        .RF_Rb_rd(RF_Rb_rd), .Alu_s0(Alu_s0)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge Clk) IM_data <= rom[IM_addr];

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    endtask

    task automatic pulse_reset();
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_st [0:3];
        logic [4:0] exp_pc [0:3];
        exp_st[0] = 4'd1; exp_st[1] = 4'd2; exp_st[2] = 4'd3; exp_st[3] = 4'd1;
        exp_pc[0] = 5'd0; exp_pc[1] = 5'd1; exp_pc[2] = 5'd1; exp_pc[3] = 5'd1;
        clear_rom();
        @(negedge Clk); Reset = 1'b1; #1;
        n_cmp++;
        if (StateO !== 4'd0 || PC_Out !== 5'd0 || IR_Out !== 16'h0 ||
            D_wr !== 1'b0 || RF_W_wr !== 1'b0 || D_addr !== 8'h0 || Alu_s0 !== 3'b000) begin
            n_err++;
            $display("FAIL reset_state: st=%0d pc=%0d ir=%h dwr=%b rfwr=%b daddr=%h alu=%b, want all 0",
                     StateO, PC_Out, IR_Out, D_wr, RF_W_wr, D_addr, Alu_s0);
        end
        @(negedge Clk); Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            n_cmp++;
            if (StateO !== exp_st[i] || PC_Out !== exp_pc[i]) begin
                n_err++;
                $display("FAIL reset_seq[%0d]: st=%0d pc=%0d, want st=%0d pc=%0d",
                         i, StateO, PC_Out, exp_st[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_arith(input logic [15:0] instr, input logic [3:0] exp_st,
                              input logic [2:0] exp_alu);
        clear_rom(); rom[0] = instr;
        pulse_reset();
        @(negedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (StateO !== 4'd2 || IR_Out !== instr || PC_Out !== 5'd1) begin
            n_err++;
            $display("FAIL arith_decode: st=%0d ir=%h pc=%0d, want st=2 ir=%h pc=1",
                     StateO, IR_Out, PC_Out, instr);
        end
        @(negedge Clk);
        n_cmp++;
        if (StateO !== exp_st || RF_Ra_addr !== instr[11:8] || RF_Rb_addr !== instr[7:4] ||
            RF_W_addr !== instr[3:0] || RF_W_wr !== 1'b1 || RF_Ra_rd !== 1'b1 ||
            RF_Rb_rd !== 1'b1 || RF_s !== 1'b0 || Alu_s0 !== exp_alu || D_wr !== 1'b0 ||
            D_addr !== 8'h00) begin
            n_err++;
            $display("FAIL arith_exec %h: st=%0d ra=%h rb=%h w=%h wwr=%b rda=%b rdb=%b s=%b alu=%b dwr=%b da=%h, want st=%0d alu=%b",
                     instr, StateO, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_wr, RF_Ra_rd,
                     RF_Rb_rd, RF_s, Alu_s0, D_wr, D_addr, exp_st, exp_alu);
        end
        @(negedge Clk);
        n_cmp++;
        if (StateO !== 4'd1 || RF_W_wr !== 1'b0 || RF_Ra_rd !== 1'b0) begin
            n_err++;
            $display("FAIL arith_after: st=%0d wwr=%b rda=%b, want st=1 wwr=0 rda=0",
                     StateO, RF_W_wr, RF_Ra_rd);
        end
    endtask

    task automatic test_load();
        logic [3:0] exp_st [0:4];
        exp_st[0] = 4'd1; exp_st[1] = 4'd2; exp_st[2] = 4'd4; exp_st[3] = 4'd5; exp_st[4] = 4'd1;
        clear_rom(); rom[0] = 16'h20A3;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            n_cmp++;
            if (StateO !== exp_st[i]) begin
                n_err++;
                $display("FAIL load_seq[%0d]: st=%0d, want %0d", i, StateO, exp_st[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if (D_addr !== 8'h0A || RF_W_wr !== 1'b0 || RF_s !== 1'b0 || D_wr !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_a: da=%h wwr=%b s=%b dwr=%b, want da=0a wwr=0 s=0 dwr=0",
                             D_addr, RF_W_wr, RF_s, D_wr);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (D_addr !== 8'h0A || RF_s !== 1'b1 || RF_W_addr !== 4'd3 ||
                    RF_W_wr !== 1'b1 || RF_Ra_rd !== 1'b0 || D_wr !== 1'b0) begin
                    n_err++;
                    $display("FAIL load_b: da=%h s=%b w=%h wwr=%b rda=%b dwr=%b, want da=0a s=1 w=3 wwr=1 rda=0 dwr=0",
                             D_addr, RF_s, RF_W_addr, RF_W_wr, RF_Ra_rd, D_wr);
                end
            end
        end
    endtask

    task automatic test_store_halt();
        int dwr_cnt = 0;
        int bad = 0;
        clear_rom(); rom[0] = 16'h1FF7; rom[1] = 16'h5000;
        pulse_reset();
        @(negedge Clk); if (D_wr) dwr_cnt++;
        @(negedge Clk); if (D_wr) dwr_cnt++;
        @(negedge Clk); if (D_wr) dwr_cnt++;
        n_cmp++;
        if (StateO !== 4'd6 || D_addr !== 8'hFF || D_wr !== 1'b1 || RF_Ra_addr !== 4'd7 ||
            RF_Ra_rd !== 1'b1 || Alu_s0 !== 3'b000 || RF_W_wr !== 1'b0 || RF_Rb_rd !== 1'b0) begin
            n_err++;
            $display("FAIL store: st=%0d da=%h dwr=%b ra=%h rda=%b alu=%b wwr=%b rdb=%b, want st=6 da=ff dwr=1 ra=7 rda=1 alu=000 wwr=0 rdb=0",
                     StateO, D_addr, D_wr, RF_Ra_addr, RF_Ra_rd, Alu_s0, RF_W_wr, RF_Rb_rd);
        end
        @(negedge Clk); if (D_wr) dwr_cnt++;
        @(negedge Clk); if (D_wr) dwr_cnt++;
        n_cmp++;
        if (StateO !== 4'd2 || IR_Out !== 16'h5000 || PC_Out !== 5'd2) begin
            n_err++;
            $display("FAIL halt_decode: st=%0d ir=%h pc=%0d, want st=2 ir=5000 pc=2",
                     StateO, IR_Out, PC_Out);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk); if (D_wr) dwr_cnt++;
            if (StateO !== 4'd9 || PC_Out !== 5'd2 || RF_W_wr !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL halt_hold: %0d of 20 cycles off, last st=%0d pc=%0d, want st=9 pc=2",
                     bad, StateO, PC_Out);
        end
        n_cmp++;
        if (dwr_cnt != 1) begin
            n_err++;
            $display("FAIL store_strobe: D_wr high %0d cycles, want 1", dwr_cnt);
        end
    endtask

    task automatic test_pc_wrap();
        logic [3:0] op;
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            op = (i % 3 == 0) ? 4'h0 : 4'(6 + (i % 10));
            rom[i] = {op, 7'd0, 5'(i)};
        end
        pulse_reset();
        for (int k = 0; k <= 32; k++) begin
            @(negedge Clk);
            @(negedge Clk);
            if (PC_Out !== 5'((k + 1) % 32) || IR_Out !== rom[k % 32] || StateO !== 4'd2) begin
                bad++;
                if (k >= 30)
                    $display("FAIL wrap_decode[%0d]: pc=%0d ir=%h st=%0d, want pc=%0d ir=%h st=2",
                             k, PC_Out, IR_Out, StateO, (k + 1) % 32, rom[k % 32]);
            end
            @(negedge Clk);
            if (StateO !== 4'd3) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL pc_wrap: %0d errors over 33 NOOPs, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_load();
        clear_rom(); rom[0] = 16'h20A3;
        pulse_reset();
        repeat (4) @(negedge Clk);
        n_cmp++;
        if (StateO !== 4'd5 || RF_W_wr !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: st=%0d wwr=%b, want st=5 wwr=1", StateO, RF_W_wr);
        end
        #1 Reset = 1'b1;
        #1;
        n_cmp++;
        if (StateO !== 4'd0 || RF_W_wr !== 1'b0 || RF_s !== 1'b0 || PC_Out !== 5'd0 ||
            IR_Out !== 16'h0 || D_addr !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_abort: st=%0d wwr=%b s=%b pc=%0d ir=%h da=%h, want all 0",
                     StateO, RF_W_wr, RF_s, PC_Out, IR_Out, D_addr);
        end
        @(negedge Clk); Reset = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        n_cmp++;
        if (StateO !== 4'd2 || PC_Out !== 5'd1 || IR_Out !== 16'h20A3) begin
            n_err++;
            $display("FAIL midrst_restart: st=%0d pc=%0d ir=%h, want st=2 pc=1 ir=20a3",
                     StateO, PC_Out, IR_Out);
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_arith(16'h3125, 4'd7, 3'b001);
        test_arith(16'h4ABC, 4'd8, 3'b010);
        test_load();
        test_store_halt();
        test_pc_wrap();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
